render_cmd_issuer: RTL and testbench
====================================

Name: render_cmd_issuer

Overview:
- Initiator side of the render command interface: buffers draw/clear commands from the host/decoder side and issues them one at a time to render_module.
- Drives start_l, end_l, op and render_enable; consumes render_done.
- Holds operands stable for a programmable setup window before enabling the renderer; drops render_enable after completion; guards against a hung renderer with a watchdog.

Parameters:
- FIFO_DEPTH, 4: command buffer entries (power of 2, >=2).
- SETUP_CYCLES, 4: cycles operands are stable before render_enable rises (>=1).
- TIMEOUT_CYCLES, 131072: maximum cycles render_enable stays high without render_done (> 320*240).

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  command buffer can accept
- cmd_op  in  3  opcode (0 clear, 1 noop, 6 draw line)
- cmd_start  in  17  {x[8:0], y[7:0]} start point
- cmd_end  in  17  {x[8:0], y[7:0]} end point
- start_l  out  17  to render_module
- end_l  out  17  to render_module
- op  out  3  to render_module
- render_enable  out  1  to render_module
- render_done  in  1  from render_module
- busy  out  1  state != IDLE or FIFO non-empty
- cmd_count  out  16  retired commands, wraps 0xFFFF->0
- timeout_err  out  1  sticky watchdog flag

Behaviour:
- One clock. rst is synchronous and active-high. All outputs are registered.
- Reset values: start_l=0, end_l=0, op=3'd1 (NOOP), render_enable=0, cmd_count=0, timeout_err=0, FIFO empty, state IDLE, cmd_ready=1, busy=0.
- Reset mid-operation: render_enable=0 after the reset edge, FIFO flushed, all counters cleared.
- FIFO:
  - Push on cmd_valid&&cmd_ready; cmd_ready = !full.
  - A push into an empty FIFO is visible to the FSM the next cycle, so first-word latency is 1.
  - A push and a pop in the same cycle are both honoured; count is unchanged.
- State IDLE:
  - FIFO non-empty, head op==1: pop, cmd_count++, stay IDLE. Outputs are not touched and render_enable is not asserted.
  - FIFO non-empty, other op: pop, load start_l/end_l/op from head, clear setup counter, go to SETUP.
- State SETUP:
  - Counter increments each cycle.
  - When counter==SETUP_CYCLES-1: go to RUN and set render_enable=1, clear watchdog.
  - With defaults, render_enable rises on the 5th edge after the accepting edge.
- State RUN:
  - render_enable=1; watchdog increments.
  - render_done sampled high: render_enable=0, cmd_count++, go to RELEASE.
  - Else if watchdog==TIMEOUT_CYCLES-1: render_enable=0, timeout_err=1, no count increment, go to RELEASE.
  - render_done takes priority over timeout on the same cycle.
- State RELEASE:
  - render_enable=0; stay while render_done==1; go to IDLE when render_done==0.
  - Minimum 1 cycle, so render_enable is low for at least 1 cycle between commands.
- start_l/end_l/op are held constant from SETUP entry through RELEASE exit, and hold their last values in IDLE.
- render_done is ignored in IDLE and SETUP.
- Back-to-back throughput: SETUP_CYCLES + render time + 2 cycles per issued command.

Test Plan:
- Reset: rst high 2 cycles -> render_enable=0, op=1, cmd_ready=1, busy=0, cmd_count=0, timeout_err=0.
- Single draw: op=6, start {10,10}=17'h00A0A, end {12,12}=17'h00C0C.
  - start_l/end_l valid 1 cycle after accept; render_enable high 5 edges after accept.
  - Model asserts render_done 20 cycles later -> render_enable low the next cycle, cmd_count=1, busy=0 once render_done falls.
- Backpressure: model stalls render_done; push 6 commands back-to-back.
  - 1st is issued; entries 2-5 fill the FIFO; cmd_ready=0 when the 6th is presented.
  - Release render_done -> the 6th is accepted, and all six are issued in order with exact operands.
- NOOP: push op=1 -> render_enable stays 0, cmd_count increments 1 cycle after accept, op output unchanged.
- Watchdog: TIMEOUT_CYCLES=64, render_done held 0.
  - render_enable is high exactly 64 cycles, then timeout_err=1 and cmd_count unchanged.
  - The next queued clear (op=0) is issued normally.
- Sticky done / reset mid-op:
  - render_done held high 10 cycles after completion -> stays in RELEASE, render_enable=0.
  - rst asserted during RUN -> render_enable=0 next cycle, FIFO empty, cmd_count=0.

Source files
------------

// File: rtl/render_cmd_issuer.sv
// ============================================================================
// render_cmd_issuer : buffers draw/clear commands and issues them one at a time
// to render_module with a setup window, completion handshake and watchdog.
// Revision: 1.0
// ============================================================================
`default_nettype none

module render_cmd_issuer #(
  parameter int FIFO_DEPTH     = 4,
  parameter int SETUP_CYCLES   = 4,
  parameter int TIMEOUT_CYCLES = 131072
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [2:0]  cmd_op,
  input  logic [16:0] cmd_start,
  input  logic [16:0] cmd_end,
  output logic [16:0] start_l,
  output logic [16:0] end_l,
  output logic [2:0]  op,
  output logic        render_enable,
  input  logic        render_done,
  output logic        busy,
  output logic [15:0] cmd_count,
  output logic        timeout_err
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int FILL_W = PTR_W + 1;
  localparam int SET_W = (SETUP_CYCLES > 1) ? $clog2(SETUP_CYCLES) : 1;
  localparam int WD_W = $clog2(TIMEOUT_CYCLES);
  localparam logic [2:0] OP_NOOP = 3'd1;
  localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(FIFO_DEPTH);
  localparam logic [SET_W-1:0] SETUP_LAST = SET_W'(SETUP_CYCLES - 1);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_SETUP   = 2'd1,
    S_RUN     = 2'd2,
    S_RELEASE = 2'd3
  } state_t;

  // Each entry packs {op, start, end}
  logic [36:0]       mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
  logic [FILL_W-1:0] fill_q, fill_d;
  logic [SET_W-1:0]  setup_cnt_q;
  logic [WD_W-1:0]   wd_q;
  state_t            state_q, state_d;

  logic        cmd_ready_q, busy_q, render_enable_q, timeout_err_q;
  logic [16:0] start_l_q, end_l_q;
  logic [2:0]  op_q;
  logic [15:0] cmd_count_q;

  logic        push, pop, head_is_noop;
  logic [36:0] head;

  assign push         = cmd_valid && cmd_ready_q;
  assign pop          = (state_q == S_IDLE) && (fill_q != '0);
  assign head         = mem_q[rd_ptr_q];
  assign head_is_noop = (head[36:34] == OP_NOOP);

  always_comb begin
    fill_d = fill_q;
    if (push && !pop)
      fill_d = fill_q + 1'b1;
    else if (!push && pop)
      fill_d = fill_q - 1'b1;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:    if (pop && !head_is_noop) state_d = S_SETUP;
      S_SETUP:   if (setup_cnt_q == SETUP_LAST) state_d = S_RUN;
      S_RUN:     if (render_done || wd_q == WD_LAST) state_d = S_RELEASE;
      S_RELEASE: if (!render_done) state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= {cmd_op, cmd_start, cmd_end};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= S_IDLE;
      wr_ptr_q        <= '0;
      rd_ptr_q        <= '0;
      fill_q          <= '0;
      setup_cnt_q     <= '0;
      wd_q            <= '0;
      cmd_ready_q     <= 1'b1;
      busy_q          <= 1'b0;
      render_enable_q <= 1'b0;
      timeout_err_q   <= 1'b0;
      start_l_q       <= '0;
      end_l_q         <= '0;
      op_q            <= OP_NOOP;
      cmd_count_q     <= '0;
    end else begin
      state_q     <= state_d;
      fill_q      <= fill_d;
      cmd_ready_q <= (fill_d != FILL_FULL);
      busy_q      <= (state_d != S_IDLE) || (fill_d != '0);
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;

      case (state_q)
        S_IDLE: begin
          if (pop) begin
            // A NOOP retires immediately and leaves the renderer outputs alone
            if (head_is_noop) begin
              cmd_count_q <= cmd_count_q + 1'b1;
            end else begin
              op_q        <= head[36:34];
              start_l_q   <= head[33:17];
              end_l_q     <= head[16:0];
              setup_cnt_q <= '0;
            end
          end
        end
        S_SETUP: begin
          setup_cnt_q <= setup_cnt_q + 1'b1;
          if (setup_cnt_q == SETUP_LAST) begin
            render_enable_q <= 1'b1;
            wd_q            <= '0;
          end
        end
        S_RUN: begin
          wd_q <= wd_q + 1'b1;
          if (render_done) begin
            render_enable_q <= 1'b0;
            cmd_count_q     <= cmd_count_q + 1'b1;
          end else if (wd_q == WD_LAST) begin
            render_enable_q <= 1'b0;
            timeout_err_q   <= 1'b1;
          end
        end
        S_RELEASE: render_enable_q <= 1'b0;
        default:   render_enable_q <= 1'b0;
      endcase
    end
  end

  assign cmd_ready     = cmd_ready_q;
  assign busy          = busy_q;
  assign render_enable = render_enable_q;
  assign timeout_err   = timeout_err_q;
  assign start_l       = start_l_q;
  assign end_l         = end_l_q;
  assign op            = op_q;
  assign cmd_count     = cmd_count_q;

endmodule

`default_nettype wire

// File: tb/tb_render_cmd_issuer.sv
// ============================================================================
// tb_render_cmd_issuer : directed self-checking bench for render_cmd_issuer.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_render_cmd_issuer;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [2:0]  cmd_op;
  logic [16:0] cmd_start;
  logic [16:0] cmd_end;
  logic [16:0] start_l;
  logic [16:0] end_l;
  logic [2:0]  op;
  logic        render_enable;
  logic        render_done;
  logic        busy;
  logic [15:0] cmd_count;
  logic        timeout_err;

  int checks = 0;
  int errors = 0;

  render_cmd_issuer #(
    .FIFO_DEPTH    (4),
    .SETUP_CYCLES  (4),
    .TIMEOUT_CYCLES(64)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_op       (cmd_op),
    .cmd_start    (cmd_start),
    .cmd_end      (cmd_end),
    .start_l      (start_l),
    .end_l        (end_l),
    .op           (op),
    .render_enable(render_enable),
    .render_done  (render_done),
    .busy         (busy),
    .cmd_count    (cmd_count),
    .timeout_err  (timeout_err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Present a command and return just after the edge that accepts it
  task automatic send(input logic [2:0] o, input logic [16:0] s, input logic [16:0] e);
    int n = 0;
    cmd_valid = 1'b1;
    cmd_op    = o;
    cmd_start = s;
    cmd_end   = e;
    while (!cmd_ready && n < 200) begin
      tick();
      n++;
    end
    chk("send_ready", {31'd0, cmd_ready}, 32'd1);
    tick();
    cmd_valid = 1'b0;
  endtask

  // Renderer model: wait for enable, check operands, finish after hold cycles
  task automatic serve(input logic [2:0] o, input logic [16:0] s, input logic [16:0] e,
                       input int hold);
    int n = 0;
    while (!render_enable && n < 100) begin
      tick();
      n++;
    end
    chk("serve_en", {31'd0, render_enable}, 32'd1);
    chk("serve_op", {29'd0, op}, {29'd0, o});
    chk("serve_start", {15'd0, start_l}, {15'd0, s});
    chk("serve_end", {15'd0, end_l}, {15'd0, e});
    repeat (hold) tick();
    render_done = 1'b1;
    tick();
    chk("serve_drop", {31'd0, render_enable}, 32'd0);
    render_done = 1'b0;
    tick();
  endtask

  initial begin
    int n;
    rst         = 1'b1;
    cmd_valid   = 1'b0;
    cmd_op      = 3'd0;
    cmd_start   = '0;
    cmd_end     = '0;
    render_done = 1'b0;

    // Reset
    tick();
    tick();
    chk("rst_en", {31'd0, render_enable}, 32'd0);
    chk("rst_op", {29'd0, op}, 32'd1);
    chk("rst_ready", {31'd0, cmd_ready}, 32'd1);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_count", {16'd0, cmd_count}, 32'd0);
    chk("rst_tmo", {31'd0, timeout_err}, 32'd0);
    chk("rst_start", {15'd0, start_l}, 32'd0);
    rst = 1'b0;
    tick();

    // Single draw: accept edge, operands one edge later, enable on 5th edge
    send(3'd6, 17'h00A0A, 17'h00C0C);
    chk("draw_en_e0", {31'd0, render_enable}, 32'd0);
    tick();
    chk("draw_start", {15'd0, start_l}, 32'h00A0A);
    chk("draw_end", {15'd0, end_l}, 32'h00C0C);
    chk("draw_op", {29'd0, op}, 32'd6);
    repeat (3) tick();
    chk("draw_en_e4", {31'd0, render_enable}, 32'd0);
    tick();
    chk("draw_en_e5", {31'd0, render_enable}, 32'd1);
    repeat (19) tick();
    chk("draw_en_hold", {31'd0, render_enable}, 32'd1);
    render_done = 1'b1;
    tick();
    chk("draw_en_low", {31'd0, render_enable}, 32'd0);
    chk("draw_count", {16'd0, cmd_count}, 32'd1);
    chk("draw_busy_rel", {31'd0, busy}, 32'd1);
    render_done = 1'b0;
    tick();
    chk("draw_busy_idle", {31'd0, busy}, 32'd0);

    // Backpressure: renderer stalled, FIFO fills behind the first command
    for (int i = 1; i <= 5; i++)
      send(3'd6, 17'h01000 + 17'(i), 17'h02000 + 17'(i));
    chk("bp_ready_full", {31'd0, cmd_ready}, 32'd0);
    cmd_valid = 1'b1;
    cmd_op    = 3'd6;
    cmd_start = 17'h01006;
    cmd_end   = 17'h02006;
    repeat (3) tick();
    chk("bp_ready_stall", {31'd0, cmd_ready}, 32'd0);
    chk("bp_count_stall", {16'd0, cmd_count}, 32'd1);
    cmd_valid = 1'b0;
    serve(3'd6, 17'h01001, 17'h02001, 0);
    send(3'd6, 17'h01006, 17'h02006);
    for (int i = 2; i <= 6; i++)
      serve(3'd6, 17'h01000 + 17'(i), 17'h02000 + 17'(i), 2);
    chk("bp_count", {16'd0, cmd_count}, 32'd7);
    chk("bp_busy", {31'd0, busy}, 32'd0);

    // NOOP retires without touching the renderer outputs
    send(3'd1, 17'h1FFFF, 17'h1FFFF);
    chk("noop_count_e0", {16'd0, cmd_count}, 32'd7);
    tick();
    chk("noop_count", {16'd0, cmd_count}, 32'd8);
    chk("noop_op", {29'd0, op}, 32'd6);
    chk("noop_start", {15'd0, start_l}, 32'h01006);
    repeat (6) tick();
    chk("noop_en", {31'd0, render_enable}, 32'd0);
    chk("noop_busy", {31'd0, busy}, 32'd0);

    // Watchdog: enable high exactly 64 cycles, then a queued clear runs
    send(3'd6, 17'h00101, 17'h00202);
    send(3'd0, 17'h00000, 17'h1FFFF);
    n = 0;
    while (!render_enable && n < 100) begin
      tick();
      n++;
    end
    n = 0;
    while (render_enable && n < 200) begin
      n++;
      tick();
    end
    chk("wd_len", 32'(n), 32'd64);
    chk("wd_tmo", {31'd0, timeout_err}, 32'd1);
    chk("wd_count", {16'd0, cmd_count}, 32'd8);
    serve(3'd0, 17'h00000, 17'h1FFFF, 3);
    chk("wd_clear_count", {16'd0, cmd_count}, 32'd9);
    chk("wd_tmo_sticky", {31'd0, timeout_err}, 32'd1);

    // Sticky done holds RELEASE with enable low
    send(3'd6, 17'h00303, 17'h00404);
    n = 0;
    while (!render_enable && n < 100) begin
      tick();
      n++;
    end
    render_done = 1'b1;
    tick();
    chk("sticky_drop", {31'd0, render_enable}, 32'd0);
    repeat (10) tick();
    chk("sticky_en", {31'd0, render_enable}, 32'd0);
    chk("sticky_busy", {31'd0, busy}, 32'd1);
    render_done = 1'b0;
    tick();
    chk("sticky_idle", {31'd0, busy}, 32'd0);
    chk("sticky_count", {16'd0, cmd_count}, 32'd10);

    // Reset during RUN with a command still queued
    send(3'd6, 17'h00505, 17'h00606);
    send(3'd6, 17'h00707, 17'h00808);
    n = 0;
    while (!render_enable && n < 100) begin
      tick();
      n++;
    end
    chk("mid_en_pre", {31'd0, render_enable}, 32'd1);
    rst = 1'b1;
    tick();
    chk("mid_en", {31'd0, render_enable}, 32'd0);
    chk("mid_count", {16'd0, cmd_count}, 32'd0);
    chk("mid_busy", {31'd0, busy}, 32'd0);
    chk("mid_tmo", {31'd0, timeout_err}, 32'd0);
    chk("mid_op", {29'd0, op}, 32'd1);
    rst = 1'b0;
    repeat (8) tick();
    chk("mid_flushed_busy", {31'd0, busy}, 32'd0);
    chk("mid_flushed_en", {31'd0, render_enable}, 32'd0);
    chk("mid_ready", {31'd0, cmd_ready}, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
